// File: rtl/memory_loader_pkg.sv
// Shared definitions for the boot-time RAM loader: state encodings and the
// RAM data width (`WIDTH, defaults to 16 when not supplied by the build).
`ifndef WIDTH
`define WIDTH 16
`endif

package memory_loader_pkg;

   localparam logic [3:0] LDR_IDLE    = 4'd0;
   localparam logic [3:0] LDR_LEN_HI  = 4'd1;
   localparam logic [3:0] LDR_LEN_LO  = 4'd2;
   localparam logic [3:0] LDR_DATA_HI = 4'd3;
   localparam logic [3:0] LDR_DATA_LO = 4'd4;
   localparam logic [3:0] LDR_WRITE   = 4'd5;
   localparam logic [3:0] LDR_CHECK   = 4'd6;
   localparam logic [3:0] LDR_DONE    = 4'd7;
   localparam logic [3:0] LDR_ERROR   = 4'd8;

   // States in which the loader consumes a byte from the host link.
   function automatic logic accepts_byte(input logic [3:0] s);
      return (s == LDR_LEN_HI) || (s == LDR_LEN_LO) || (s == LDR_DATA_HI) ||
             (s == LDR_DATA_LO) || (s == LDR_CHECK);
   endfunction

   function automatic logic is_quiescent(input logic [3:0] s);
      return (s == LDR_IDLE) || (s == LDR_DONE) || (s == LDR_ERROR);
   endfunction

endpackage

// File: rtl/memory_loader_checksum.sv
// 8-bit running XOR over the data bytes of a load frame; used only when
// LOADER_CHECKSUM_EN is defined.
module loader_checksum (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       clear_i,
   input  logic       acc_i,
   input  logic [7:0] data_i,
   output logic [7:0] sum_o
);

   logic [7:0] sum_q;

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         sum_q <= 8'h00;
      end else if (clear_i) begin
         sum_q <= 8'h00;
      end else if (acc_i) begin
         sum_q <= sum_q ^ data_i;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/memory_loader.sv
// Boot loader: length-prefixed big-endian byte stream -> consecutive RAM words,
// CPU held until the image is in place. Optional trailing XOR byte: LOADER_CHECKSUM_EN.
module memory_loader
   import memory_loader_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          DEPTH     = 32
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   output logic [15:0]       memory_address_o,
   output logic              memory_write_enable_o,
   output logic [`WIDTH-1:0] memory_data_out_o,
   output logic              cpu_hold_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o
);

   logic [3:0]  state_q, state_d;
   logic [7:0]  len_hi_q, len_hi_d;
   logic [7:0]  hi_q, hi_d;
   logic [15:0] len_q, len_d;
   logic [15:0] index_q, index_d;
   logic [15:0] data_q, data_d;

   logic        xfer;
   logic        start_ok;
   logic [15:0] len_w;
   logic        last_w;

   assign xfer     = rx_valid_i & rx_ready_o;
   assign start_ok = start_i & is_quiescent(state_q);
   assign len_w    = {len_hi_q, rx_data_i};
   assign last_w   = (index_q + 16'd1) == len_q;

`ifdef LOADER_CHECKSUM_EN
   localparam logic [3:0] AFTER_DATA = LDR_CHECK;
   logic [7:0] chk_w;

   loader_checksum u_checksum (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .clear_i (start_ok),
      .acc_i   (xfer && (state_q == LDR_DATA_HI || state_q == LDR_DATA_LO)),
      .data_i  (rx_data_i),
      .sum_o   (chk_w)
   );
`else
   localparam logic [3:0] AFTER_DATA = LDR_DONE;
`endif

   always_comb begin
      state_d  = state_q;
      len_hi_d = len_hi_q;
      hi_d     = hi_q;
      len_d    = len_q;
      index_d  = index_q;
      data_d   = data_q;
      case (state_q)
         LDR_IDLE, LDR_DONE, LDR_ERROR: begin
            if (start_ok) begin
               state_d = LDR_LEN_HI;
               index_d = 16'd0;
            end
         end
         LDR_LEN_HI: begin
            if (xfer) begin
               len_hi_d = rx_data_i;
               state_d  = LDR_LEN_LO;
            end
         end
         LDR_LEN_LO: begin
            if (xfer) begin
               len_d = len_w;
               if (len_w > 16'(DEPTH))  state_d = LDR_ERROR;
               else if (len_w == 16'd0) state_d = AFTER_DATA;
               else                     state_d = LDR_DATA_HI;
            end
         end
         LDR_DATA_HI: begin
            if (xfer) begin
               hi_d    = rx_data_i;
               state_d = LDR_DATA_LO;
            end
         end
         LDR_DATA_LO: begin
            if (xfer) begin
               data_d  = {hi_q, rx_data_i};
               state_d = LDR_WRITE;
            end
         end
         LDR_WRITE: begin
            index_d = index_q + 16'd1;
            state_d = last_w ? AFTER_DATA : LDR_DATA_HI;
         end
`ifdef LOADER_CHECKSUM_EN
         LDR_CHECK: begin
            if (xfer) state_d = (rx_data_i == chk_w) ? LDR_DONE : LDR_ERROR;
         end
`endif
         default: state_d = LDR_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= LDR_IDLE;
         len_hi_q <= 8'h00;
         hi_q     <= 8'h00;
         len_q    <= 16'd0;
         index_q  <= 16'd0;
         data_q   <= 16'd0;
      end else begin
         state_q  <= state_d;
         len_hi_q <= len_hi_d;
         hi_q     <= hi_d;
         len_q    <= len_d;
         index_q  <= index_d;
         data_q   <= data_d;
      end
   end

   // Address wraps mod 2^16 by construction; outputs decode straight from state.
   assign rx_ready_o            = accepts_byte(state_q);
   assign memory_write_enable_o = (state_q == LDR_WRITE);
   assign memory_address_o      = BASE_ADDR + index_q;
   assign memory_data_out_o     = `WIDTH'(data_q);
   assign cpu_hold_o            = (state_q != LDR_DONE);
   assign busy_o                = !is_quiescent(state_q);
   assign done_o                = (state_q == LDR_DONE);
   assign error_o               = (state_q == LDR_ERROR);

endmodule

// File: tb/tb_memory_loader.sv
// Scoreboard bench for memory_loader: expected RAM writes are queued by the
// stimulus and popped by a write-strobe monitor. Honours LOADER_CHECKSUM_EN.
`ifndef WIDTH
`define WIDTH 16
`endif

module tb_memory_loader;

   localparam logic [15:0] BASE  = 16'h0000;
   localparam int          DEPTH = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [15:0]       mem_addr;
   logic              mem_we;
   logic [`WIDTH-1:0] mem_data;
   logic              cpu_hold, busy, done, error;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [31:0] exp_q[$];
   logic [15:0] words_q[$];

   memory_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clock_i(clk), .reset_i(rst), .start_i(start),
      .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
      .memory_address_o(mem_addr), .memory_write_enable_o(mem_we),
      .memory_data_out_o(mem_data), .cpu_hold_o(cpu_hold),
      .busy_o(busy), .done_o(done), .error_o(error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Monitor: every write strobe must match the head of the expectation queue.
   always @(negedge clk) begin
      if (!rst && mem_we) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_write: addr %h data %h, no write expected", mem_addr, mem_data);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            $display("write addr=%h data=%h (expected %h/%h)", mem_addr, mem_data, e[31:16], e[15:0]);
            check("write_addr", 32'(mem_addr), 32'(e[31:16]));
            check("write_data", 32'(mem_data), 32'(e[15:0]));
         end
      end
   end

   // Called and returns at a negedge; holds the byte until accepted.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      for (int c = 0; c < 100; c++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'hEE;
            @(negedge clk);
         end else begin
            rx_valid = 1'b1;
            rx_data  = b;
            if (rx_ready) begin
               @(negedge clk);
               rx_valid = 1'b0;
               return;
            end
            @(negedge clk);
         end
      end
      rx_valid = 1'b0;
      total_cnt++;
      $display("FAIL byte_timeout: byte %h not accepted in 100 cycles", b);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_frame(input int n, input bit gaps);
      logic [15:0] len;
      logic [15:0] w;
      logic [7:0]  chk;
      len = 16'(n);
      chk = 8'h00;
      send_byte(len[15:8], gaps);
      send_byte(len[7:0], gaps);
      if (n > DEPTH) return;
      for (int i = 0; i < n; i++) begin
         w = words_q[i];
         exp_q.push_back({BASE + 16'(i), w});
         send_byte(w[15:8], gaps);
         send_byte(w[7:0], gaps);
         chk = chk ^ w[15:8] ^ w[7:0];
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(chk, gaps);
`endif
   endtask

   task automatic wait_end();
      int c;
      c = 0;
      while (!(done || error) && c < 200) begin
         @(negedge clk);
         c++;
      end
      if (c == 200) begin
         total_cnt++;
         $display("FAIL end_timeout: neither done nor error within 200 cycles");
      end
   endtask

   task automatic check_status(input string tag, input bit d, input bit e, input bit h);
      $display("%s: done=%b error=%b cpu_hold=%b busy=%b", tag, done, error, cpu_hold, busy);
      check({tag, "_done"},     32'(done),     32'(d));
      check({tag, "_error"},    32'(error),    32'(e));
      check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
      check({tag, "_busy"},     32'(busy),     32'(0));
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'(0));
   endtask

   task automatic check_reset(input string tag);
      $display("%s: reset outputs", tag);
      check({tag, "_rx_ready"}, 32'(rx_ready), 32'(0));
      check({tag, "_we"},       32'(mem_we),   32'(0));
      check({tag, "_addr"},     32'(mem_addr), 32'(BASE));
      check({tag, "_data"},     32'(mem_data), 32'(0));
      check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(1));
      check({tag, "_busy"},     32'(busy),     32'(0));
      check({tag, "_done"},     32'(done),     32'(0));
      check({tag, "_error"},    32'(error),    32'(0));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (2) @(negedge clk);
      check_reset("t1_reset");
      rst = 1'b0;
      @(negedge clk);

      // 1: basic two-word load
      words_q = '{16'h1234, 16'hABCD};
      pulse_start();
      check("t1_busy_after_start", 32'(busy), 32'(1));
      send_frame(2, 1'b0);
      wait_end();
      check_status("t1_end", 1'b1, 1'b0, 1'b0);

      // 2: same frame with random valid gaps
      pulse_start();
      check("t2_done_cleared", 32'(done), 32'(0));
      send_frame(2, 1'b1);
      wait_end();
      check_status("t2_end", 1'b1, 1'b0, 1'b0);

      // 3: length DEPTH+1 rejected straight after LEN_LO
      pulse_start();
      send_frame(DEPTH + 1, 1'b0);
      check_status("t3_err", 1'b0, 1'b1, 1'b1);
      check("t3_rx_ready", 32'(rx_ready), 32'(0));

      // 3b: length exactly DEPTH accepted
      words_q = {};
      for (int i = 0; i < DEPTH; i++) words_q.push_back({8'(i), ~8'(i)});
      pulse_start();
      send_frame(DEPTH, 1'b0);
      wait_end();
      check_status("t3b_full", 1'b1, 1'b0, 1'b0);

      // 4: empty image
      pulse_start();
      send_frame(0, 1'b0);
      wait_end();
      check_status("t4_empty", 1'b1, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      wait_end();
      check_status("t4_badchk", 1'b0, 1'b1, 1'b1);
`endif

      // 5: reset after first write of a 3-word load, then reload
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h03, 1'b0);
      exp_q.push_back({BASE, 16'h1122});
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      check("t5_first_we", 32'(mem_we), 32'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset("t5_midreset");
      rx_valid = 1'b1; rx_data = 8'h33;
      repeat (3) @(negedge clk);
      rx_valid = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_sb_empty", 32'(exp_q.size()), 32'(0));
      words_q = '{16'h0102, 16'h0304, 16'h0506};
      pulse_start();
      send_frame(3, 1'b0);
      wait_end();
      check_status("t5_reload", 1'b1, 1'b0, 1'b0);

      // 6: start during DATA_LO is ignored
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      exp_q.push_back({BASE, 16'h1234});
      exp_q.push_back({BASE + 16'd1, 16'hABCD});
      send_byte(8'h12, 1'b0);
      pulse_start();
      send_byte(8'h34, 1'b0);
      send_byte(8'hAB, 1'b0);
      send_byte(8'hCD, 1'b0);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD, 1'b0);
`endif
      wait_end();
      check_status("t6_end", 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
